// File: rtl/init_seq_pkg.sv
// init_seq_pkg: shared types and helpers for the init_sequencer block.
//   init_seq_state_t : sequencer FSM state (3-bit encoding)
//   idx_width()      : width of the step index register for a given step count
package init_seq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StDelay   = 3'd1,
        StWaitAck = 3'd2,
        StDone    = 3'd3,
        StFault   = 3'd4
    } init_seq_state_t;

    // A single-step sequencer still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/init_seq_dncnt.sv
// init_seq_dncnt: loadable down-counter that saturates at zero.
//   clk, nrst : clock, synchronous active-low reset (clears count)
//   load      : load load_val (has priority over ena)
//   load_val  : value to load
//   ena       : decrement by one if count is non-zero
//   is_zero   : count == 0
//   is_one    : count == 1
module init_seq_dncnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ena,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (ena && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == WIDTH'(1));

endmodule

// File: rtl/init_sequencer.sv
// init_sequencer: walks STEPS targets in order; for each one waits a per-step
// delay (suspended while start is low), raises a sticky enable plus a one-cycle
// strobe, then waits for that target's ack with an optional timeout.
//   clk, nrst  : clock, synchronous active-low reset
//   start      : level go; delay phases only advance while high
//   step_ack   : per-target ack level, only bit idx is looked at in WAIT_ACK
//   step_en    : sticky per-target enable (all cleared on fault)
//   step_pulse : one-cycle strobe on each step_en rising edge
//   busy       : in DELAY or WAIT_ACK
//   done       : all steps acked (terminal until reset)
//   fault      : ack timeout (terminal until reset)
//   fault_step : index of the timed-out step, 0 otherwise
module init_sequencer
    import init_seq_pkg::*;
#(
    parameter int unsigned              STEPS       = 4,
    parameter int unsigned              DELAY_W     = 16,
    parameter logic [STEPS*DELAY_W-1:0] STEP_DELAY  = '0,
    parameter int unsigned              TMO_W       = 16,
    parameter int unsigned              ACK_TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic [STEPS-1:0]           step_ack,
    output logic [STEPS-1:0]           step_en,
    output logic [STEPS-1:0]           step_pulse,
    output logic                       busy,
    output logic                       done,
    output logic                       fault,
    output logic [$clog2(STEPS+1)-1:0] fault_step
);

    localparam int unsigned      IDX_W    = idx_width(STEPS);
    localparam int unsigned      FS_W     = $clog2(STEPS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT);

    init_seq_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [STEPS-1:0] step_en_q, step_en_d;
    logic [STEPS-1:0] step_pulse_q, step_pulse_d;
    logic [FS_W-1:0]  fault_step_q, fault_step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic               d_load, d_ena, d_zero, d_one_unused;
    logic [DELAY_W-1:0] d_load_val;
    logic               t_load, t_ena, t_zero, t_one;

    // Per-step delay table unpacked from the flat parameter vector.
    logic [DELAY_W-1:0] delay_tab [STEPS];
    for (genvar g = 0; g < STEPS; g++) begin : g_delay_tab
        assign delay_tab[g] = STEP_DELAY[g*DELAY_W +: DELAY_W];
    end

    assign idx_inc = idx_q + 1'b1;

    init_seq_dncnt #(
        .WIDTH(DELAY_W)
    ) u_delay_cnt (
        .clk     (clk),
        .nrst    (nrst),
        .load    (d_load),
        .load_val(d_load_val),
        .ena     (d_ena),
        .is_zero (d_zero),
        .is_one  (d_one_unused)
    );

    init_seq_dncnt #(
        .WIDTH(TMO_W)
    ) u_tmo_cnt (
        .clk     (clk),
        .nrst    (nrst),
        .load    (t_load),
        .load_val(TMO_LOAD),
        .ena     (t_ena),
        .is_zero (t_zero),
        .is_one  (t_one)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        step_en_d    = step_en_q;
        step_pulse_d = '0;
        fault_step_d = fault_step_q;
        d_load       = 1'b0;
        d_load_val   = delay_tab[0];
        d_ena        = 1'b0;
        t_load       = 1'b0;
        t_ena        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDelay;
                    idx_d   = '0;
                    d_load  = 1'b1;
                end
            end
            StDelay: begin
                // An expired delay fires even if start has dropped meanwhile.
                if (d_zero) begin
                    step_en_d[idx_q]    = 1'b1;
                    step_pulse_d[idx_q] = 1'b1;
                    t_load              = 1'b1;
                    state_d             = StWaitAck;
                end else begin
                    d_ena = start;
                end
            end
            StWaitAck: begin
                // Ack is checked first so it wins over a same-edge timeout.
                if (step_ack[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        idx_d      = idx_inc;
                        d_load     = 1'b1;
                        d_load_val = delay_tab[idx_inc];
                        state_d    = StDelay;
                    end
                end else if (!t_zero) begin
                    // A zero count here only happens with timeout disabled.
                    if (t_one) begin
                        state_d      = StFault;
                        step_en_d    = '0;
                        fault_step_d = FS_W'(idx_q);
                    end else begin
                        t_ena = 1'b1;
                    end
                end
            end
            StDone, StFault: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d  = (state_d == StDelay) || (state_d == StWaitAck);
        done_d  = (state_d == StDone);
        fault_d = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            step_en_q    <= '0;
            step_pulse_q <= '0;
            fault_step_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            step_en_q    <= step_en_d;
            step_pulse_q <= step_pulse_d;
            fault_step_q <= fault_step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    assign step_en    = step_en_q;
    assign step_pulse = step_pulse_q;
    assign fault_step = fault_step_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;

endmodule
